// File: rtl/bsg_mem_1r1w_arb.sv
// Arbiter/sequencer for a 1R1W async-read RAM without same-address R/W support.
// Clears the RAM after reset, round-robins two writers, and bypasses colliding reads.
module bsg_mem_1r1w_arb #(
    parameter int width_p = 32,
    parameter int els_p = 16,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     w0_v_i,
    input  logic [addr_width_lp-1:0] w0_addr_i,
    input  logic [width_p-1:0]       w0_data_i,
    output logic                     w0_yumi_o,

    input  logic                     w1_v_i,
    input  logic [addr_width_lp-1:0] w1_addr_i,
    input  logic [width_p-1:0]       w1_data_i,
    output logic                     w1_yumi_o,

    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic                     r_ready_o,
    output logic                     r_v_o,
    output logic [width_p-1:0]       r_data_o,

    output logic                     mem_w_v_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,
    output logic                     mem_r_v_o,
    output logic [addr_width_lp-1:0] mem_r_addr_o,
    input  logic [width_p-1:0]       mem_r_data_i,

    output logic                     init_done_o,
    output logic                     err_o
);

    typedef enum logic {INIT, RUN} state_e;

    localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp + 1)'(els_p);
    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                     state_q, state_d;
    logic [addr_width_lp-1:0]   clr_q, clr_d;
    logic                       last_q, last_d;
    logic                       r_v_q, r_v_d;
    logic [width_p-1:0]         r_data_q, r_data_d;
    logic                       err_q, err_d;

    logic                       run;
    logic                       w0_gnt, w1_gnt, w_gnt;
    logic [addr_width_lp-1:0]   gnt_addr;
    logic [width_p-1:0]         gnt_data;
    logic                       w_in_range, r_in_range;
    logic                       r_acc, hazard;

    // Round-robin: on contention the requester that was not granted last wins.
    assign run        = (state_q == RUN);
    assign w0_gnt     = run & w0_v_i & (~w1_v_i | last_q);
    assign w1_gnt     = run & w1_v_i & (~w0_v_i | ~last_q);
    assign w_gnt      = w0_gnt | w1_gnt;
    assign gnt_addr   = w1_gnt ? w1_addr_i : w0_addr_i;
    assign gnt_data   = w1_gnt ? w1_data_i : w0_data_i;
    assign w_in_range = ({1'b0, gnt_addr} < els_lp);

    assign r_acc      = run & r_v_i;
    assign r_in_range = ({1'b0, r_addr_i} < els_lp);
    // An out-of-range write never reaches the RAM, so it must not be bypassed.
    assign hazard     = r_acc & w_gnt & w_in_range & (r_addr_i == gnt_addr);

    assign w0_yumi_o    = w0_gnt;
    assign w1_yumi_o    = w1_gnt;
    assign mem_w_v_o    = reset_n_i & (run ? (w_gnt & w_in_range) : 1'b1);
    assign mem_w_addr_o = run ? gnt_addr : clr_q;
    assign mem_w_data_o = run ? gnt_data : '0;
    assign mem_r_v_o    = r_acc & r_in_range & ~hazard;
    assign mem_r_addr_o = r_acc ? r_addr_i : '0;

    assign r_ready_o   = run;
    assign init_done_o = run;
    assign r_v_o       = r_v_q;
    assign r_data_o    = r_data_q;
    assign err_o       = err_q;

    always_comb begin
        state_d  = state_q;
        clr_d    = clr_q;
        last_d   = last_q;
        r_v_d    = r_acc;
        r_data_d = r_data_q;
        err_d    = err_q;

        case (state_q)
            INIT: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == last_addr_lp) begin
                    clr_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w1_gnt) begin
                    last_d = 1'b1;
                end else if (w0_gnt) begin
                    last_d = 1'b0;
                end
                if (r_acc) begin
                    if (hazard) begin
                        r_data_d = gnt_data;
                    end else if (r_in_range) begin
                        r_data_d = mem_r_data_i;
                    end else begin
                        r_data_d = '0;
                    end
                end
                if ((w_gnt & ~w_in_range) | (r_acc & ~r_in_range)) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= INIT;
            clr_q    <= '0;
            last_q   <= 1'b1;
            r_v_q    <= 1'b0;
            r_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            last_q   <= last_d;
            r_v_q    <= r_v_d;
            r_data_q <= r_data_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_bsg_mem_1r1w_arb.sv
// Directed bench for bsg_mem_1r1w_arb: a 16-entry instance for the main
// function and a 12-entry instance for out-of-range behaviour.
module tb_bsg_mem_1r1w_arb;

    logic clk;
    logic reset_n;

    logic        a_w0_v, a_w1_v, a_r_v;
    logic [3:0]  a_w0_addr, a_w1_addr, a_r_addr;
    logic [31:0] a_w0_data, a_w1_data;
    logic        a_w0_yumi, a_w1_yumi, a_r_ready, a_r_v_o;
    logic [31:0] a_r_data;
    logic        a_mem_w_v, a_mem_r_v;
    logic [3:0]  a_mem_w_addr, a_mem_r_addr;
    logic [31:0] a_mem_w_data, a_mem_r_data;
    logic        a_init_done, a_err;

    logic        b_w0_v, b_w1_v, b_r_v;
    logic [3:0]  b_w0_addr, b_w1_addr, b_r_addr;
    logic [31:0] b_w0_data, b_w1_data;
    logic        b_w0_yumi, b_w1_yumi, b_r_ready, b_r_v_o;
    logic [31:0] b_r_data;
    logic        b_mem_w_v, b_mem_r_v;
    logic [3:0]  b_mem_w_addr, b_mem_r_addr;
    logic [31:0] b_mem_w_data, b_mem_r_data;
    logic        b_init_done, b_err;

    logic [31:0] ramA [16];
    logic [31:0] ramB [16];

    int checks = 0;
    int failures = 0;
    int collisions = 0;

    bsg_mem_1r1w_arb #(.width_p(32), .els_p(16)) dutA (
        .clk_i(clk), .reset_n_i(reset_n),
        .w0_v_i(a_w0_v), .w0_addr_i(a_w0_addr), .w0_data_i(a_w0_data), .w0_yumi_o(a_w0_yumi),
        .w1_v_i(a_w1_v), .w1_addr_i(a_w1_addr), .w1_data_i(a_w1_data), .w1_yumi_o(a_w1_yumi),
        .r_v_i(a_r_v), .r_addr_i(a_r_addr), .r_ready_o(a_r_ready),
        .r_v_o(a_r_v_o), .r_data_o(a_r_data),
        .mem_w_v_o(a_mem_w_v), .mem_w_addr_o(a_mem_w_addr), .mem_w_data_o(a_mem_w_data),
        .mem_r_v_o(a_mem_r_v), .mem_r_addr_o(a_mem_r_addr), .mem_r_data_i(a_mem_r_data),
        .init_done_o(a_init_done), .err_o(a_err)
    );

    bsg_mem_1r1w_arb #(.width_p(32), .els_p(12)) dutB (
        .clk_i(clk), .reset_n_i(reset_n),
        .w0_v_i(b_w0_v), .w0_addr_i(b_w0_addr), .w0_data_i(b_w0_data), .w0_yumi_o(b_w0_yumi),
        .w1_v_i(b_w1_v), .w1_addr_i(b_w1_addr), .w1_data_i(b_w1_data), .w1_yumi_o(b_w1_yumi),
        .r_v_i(b_r_v), .r_addr_i(b_r_addr), .r_ready_o(b_r_ready),
        .r_v_o(b_r_v_o), .r_data_o(b_r_data),
        .mem_w_v_o(b_mem_w_v), .mem_w_addr_o(b_mem_w_addr), .mem_w_data_o(b_mem_w_data),
        .mem_r_v_o(b_mem_r_v), .mem_r_addr_o(b_mem_r_addr), .mem_r_data_i(b_mem_r_data),
        .init_done_o(b_init_done), .err_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural async-read RAMs standing in for the real instances.
    always @(posedge clk) begin
        if (a_mem_w_v) ramA[a_mem_w_addr] <= a_mem_w_data;
        if (b_mem_w_v) ramB[b_mem_w_addr] <= b_mem_w_data;
    end
    assign a_mem_r_data = ramA[a_mem_r_addr];
    assign b_mem_r_data = ramB[b_mem_r_addr];

    always @(negedge clk) begin
        if (reset_n && a_mem_w_v && a_mem_r_v && (a_mem_w_addr == a_mem_r_addr)) collisions++;
        if (reset_n && b_mem_w_v && b_mem_r_v && (b_mem_w_addr == b_mem_r_addr)) collisions++;
    end

    typedef struct {
        logic        w0v; logic [3:0] w0a; logic [31:0] w0d;
        logic        w1v; logic [3:0] w1a; logic [31:0] w1d;
        logic        rv;  logic [3:0] ra;
        logic        ey0; logic ey1;
        logic        emwv; logic [3:0] emwa; logic [31:0] emwd;
        logic        emrv; logic [3:0] emra;
        logic        erv; logic [31:0] erd;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        a_w0_v = v.w0v; a_w0_addr = v.w0a; a_w0_data = v.w0d;
        a_w1_v = v.w1v; a_w1_addr = v.w1a; a_w1_data = v.w1d;
        a_r_v  = v.rv;  a_r_addr  = v.ra;
    endtask

    task automatic clearInputs();
        a_w0_v = 0; a_w0_addr = 0; a_w0_data = 0;
        a_w1_v = 0; a_w1_addr = 0; a_w1_data = 0;
        a_r_v  = 0; a_r_addr  = 0;
        b_w0_v = 0; b_w0_addr = 0; b_w0_data = 0;
        b_w1_v = 0; b_w1_addr = 0; b_w1_data = 0;
        b_r_v  = 0; b_r_addr  = 0;
    endtask

    // Called right after reset release; a held w0 request must be ignored throughout.
    task automatic checkInit(input string tag);
        a_w0_v = 1; a_w0_addr = 4'd9; a_w0_data = 32'hFF;
        for (int i = 0; i < 16; i++) begin
            #1;
            checkOutput($sformatf("%s a_init_wv%0d", tag, i), 32'(a_mem_w_v), 32'd1);
            checkOutput($sformatf("%s a_init_wa%0d", tag, i), 32'(a_mem_w_addr), 32'(i));
            checkOutput($sformatf("%s a_init_wd%0d", tag, i), a_mem_w_data, 32'd0);
            checkOutput($sformatf("%s a_init_done%0d", tag, i), 32'(a_init_done), 32'd0);
            checkOutput($sformatf("%s a_init_yumi%0d", tag, i), 32'(a_w0_yumi), 32'd0);
            checkOutput($sformatf("%s a_init_rdy%0d", tag, i), 32'(a_r_ready), 32'd0);
            checkOutput($sformatf("%s b_init_done%0d", tag, i), 32'(b_init_done), 32'(i >= 12));
            checkOutput($sformatf("%s b_init_wv%0d", tag, i), 32'(b_mem_w_v), 32'(i < 12));
            tick();
        end
        a_w0_v = 0;
        #1;
        checkOutput($sformatf("%s a_done_after_init", tag), 32'(a_init_done), 32'd1);
        checkOutput($sformatf("%s a_ready_after_init", tag), 32'(a_r_ready), 32'd1);
        tick();
    endtask

    initial begin
        vecs[0]  = '{0,0,0,         0,0,0,           0,0, 0,0, 0,0,0,            0,0, 1,32'h0};
        vecs[1]  = '{1,1,32'hA,     1,2,32'hB,       0,0, 1,0, 1,1,32'hA,        0,0, 0,0};
        vecs[2]  = '{1,1,32'hA,     1,2,32'hB,       0,0, 0,1, 1,2,32'hB,        0,0, 0,0};
        vecs[3]  = '{1,1,32'hA,     1,2,32'hB,       0,0, 1,0, 1,1,32'hA,        0,0, 0,0};
        vecs[4]  = '{1,1,32'hA,     1,2,32'hB,       0,0, 0,1, 1,2,32'hB,        0,0, 0,0};
        vecs[5]  = '{1,5,32'h1234,  0,0,0,           0,0, 1,0, 1,5,32'h1234,     0,0, 0,0};
        vecs[6]  = '{0,0,0,         0,0,0,           1,5, 0,0, 0,0,0,            1,5, 0,0};
        vecs[7]  = '{0,0,0,         0,0,0,           0,0, 0,0, 0,0,0,            0,0, 1,32'h1234};
        vecs[8]  = '{0,0,0,         1,3,32'hDEAD,    1,3, 0,1, 1,3,32'hDEAD,     0,0, 0,0};
        vecs[9]  = '{0,0,0,         0,0,0,           1,3, 0,0, 0,0,0,            1,3, 1,32'hDEAD};
        vecs[10] = '{0,0,0,         0,0,0,           0,0, 0,0, 0,0,0,            0,0, 1,32'hDEAD};
        vecs[11] = '{1,7,32'h77,    0,0,0,           1,1, 1,0, 1,7,32'h77,       1,1, 0,0};
        vecs[12] = '{0,0,0,         0,0,0,           0,0, 0,0, 0,0,0,            0,0, 1,32'hA};
        vecs[13] = '{0,0,0,         0,0,0,           1,7, 0,0, 0,0,0,            1,7, 0,0};
        vecs[14] = '{0,0,0,         0,0,0,           1,2, 0,0, 0,0,0,            1,2, 1,32'h77};
        vecs[15] = '{0,0,0,         0,0,0,           1,7, 0,0, 0,0,0,            1,7, 1,32'hB};
        vecs[16] = '{0,0,0,         0,0,0,           0,0, 0,0, 0,0,0,            0,0, 1,32'h77};

        clearInputs();
        reset_n = 1'b0;
        #1;
        checkOutput("rst a_wv", 32'(a_mem_w_v), 32'd0);
        checkOutput("rst a_rv", 32'(a_r_v_o), 32'd0);
        checkOutput("rst a_rdata", a_r_data, 32'd0);
        checkOutput("rst a_err", 32'(a_err), 32'd0);
        checkOutput("rst a_done", 32'(a_init_done), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        checkInit("first");

        // Every location reads back as zero after the clear.
        for (int i = 0; i < 16; i++) begin
            a_r_v = 1; a_r_addr = 4'(i);
            #1;
            checkOutput($sformatf("rd0 mrv%0d", i), 32'(a_mem_r_v), 32'd1);
            if (i > 0) begin
                checkOutput($sformatf("rd0 rv%0d", i - 1), 32'(a_r_v_o), 32'd1);
                checkOutput($sformatf("rd0 rdata%0d", i - 1), a_r_data, 32'd0);
            end
            tick();
        end

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d y0", i), 32'(a_w0_yumi), 32'(vecs[i].ey0));
            checkOutput($sformatf("vec%0d y1", i), 32'(a_w1_yumi), 32'(vecs[i].ey1));
            checkOutput($sformatf("vec%0d mwv", i), 32'(a_mem_w_v), 32'(vecs[i].emwv));
            if (vecs[i].emwv) begin
                checkOutput($sformatf("vec%0d mwa", i), 32'(a_mem_w_addr), 32'(vecs[i].emwa));
                checkOutput($sformatf("vec%0d mwd", i), a_mem_w_data, vecs[i].emwd);
            end
            checkOutput($sformatf("vec%0d mrv", i), 32'(a_mem_r_v), 32'(vecs[i].emrv));
            if (vecs[i].emrv)
                checkOutput($sformatf("vec%0d mra", i), 32'(a_mem_r_addr), 32'(vecs[i].emra));
            checkOutput($sformatf("vec%0d rv", i), 32'(a_r_v_o), 32'(vecs[i].erv));
            if (vecs[i].erv)
                checkOutput($sformatf("vec%0d rdata", i), a_r_data, vecs[i].erd);
            checkOutput($sformatf("vec%0d err", i), 32'(a_err), 32'd0);
            tick();
        end
        clearInputs();

        // Out-of-range handling on the 12-entry instance.
        b_w1_v = 1; b_w1_addr = 4'd2; b_w1_data = 32'h55;
        #1;
        checkOutput("b w1 yumi", 32'(b_w1_yumi), 32'd1);
        checkOutput("b w1 mwv", 32'(b_mem_w_v), 32'd1);
        tick();
        clearInputs();
        b_r_v = 1; b_r_addr = 4'd2;
        #1;
        checkOutput("b rd2 mrv", 32'(b_mem_r_v), 32'd1);
        tick();
        clearInputs();
        b_w0_v = 1; b_w0_addr = 4'd13; b_w0_data = 32'h99;
        #1;
        checkOutput("b rd2 rv", 32'(b_r_v_o), 32'd1);
        checkOutput("b rd2 rdata", b_r_data, 32'h55);
        checkOutput("b oow yumi", 32'(b_w0_yumi), 32'd1);
        checkOutput("b oow mwv", 32'(b_mem_w_v), 32'd0);
        checkOutput("b err before", 32'(b_err), 32'd0);
        tick();
        clearInputs();
        b_w0_v = 1; b_w0_addr = 4'd1; b_w0_data = 32'h1;
        b_w1_v = 1; b_w1_addr = 4'd4; b_w1_data = 32'h4;
        #1;
        checkOutput("b err set", 32'(b_err), 32'd1);
        checkOutput("b last upd y0", 32'(b_w0_yumi), 32'd0);
        checkOutput("b last upd y1", 32'(b_w1_yumi), 32'd1);
        tick();
        clearInputs();
        b_w0_v = 1; b_w0_addr = 4'd13; b_w0_data = 32'h77;
        b_r_v = 1; b_r_addr = 4'd13;
        #1;
        checkOutput("b oo both y0", 32'(b_w0_yumi), 32'd1);
        checkOutput("b oo both mwv", 32'(b_mem_w_v), 32'd0);
        checkOutput("b oo both mrv", 32'(b_mem_r_v), 32'd0);
        tick();
        clearInputs();
        b_r_v = 1; b_r_addr = 4'd2;
        #1;
        checkOutput("b no bypass rv", 32'(b_r_v_o), 32'd1);
        checkOutput("b no bypass rdata", b_r_data, 32'd0);
        tick();
        b_r_addr = 4'd14;
        #1;
        checkOutput("b oor mrv", 32'(b_mem_r_v), 32'd0);
        checkOutput("b rd2b rdata", b_r_data, 32'h55);
        tick();
        clearInputs();
        #1;
        checkOutput("b oor rv", 32'(b_r_v_o), 32'd1);
        checkOutput("b oor rdata", b_r_data, 32'd0);
        checkOutput("b err sticky", 32'(b_err), 32'd1);
        tick();

        // Reset pulsed with a read response in flight.
        a_r_v = 1; a_r_addr = 4'd5;
        tick();
        clearInputs();
        #1;
        checkOutput("pend rv", 32'(a_r_v_o), 32'd1);
        checkOutput("pend rdata", a_r_data, 32'h1234);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst a_rv", 32'(a_r_v_o), 32'd0);
        checkOutput("midrst a_rdata", a_r_data, 32'd0);
        checkOutput("midrst a_wv", 32'(a_mem_w_v), 32'd0);
        checkOutput("midrst a_done", 32'(a_init_done), 32'd0);
        checkOutput("midrst b_err", 32'(b_err), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        checkInit("rerun");
        a_r_v = 1; a_r_addr = 4'd3;
        tick();
        clearInputs();
        #1;
        checkOutput("post rst rv", 32'(a_r_v_o), 32'd1);
        checkOutput("post rst rdata", a_r_data, 32'd0);
        tick();

        checkOutput("no_rw_collision", 32'(collisions), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
